uc_seq: RTL and testbench
=========================

// Module: uc_seq
// PURPOSE
// - Next-generation control unit for the didactic calculator. It replaces the
//   fixed 3-cycle fetch with a ram_rdy wait-state handshake.
// - Decodes a small ISA: NOP, INC, LD, JMP, JZ, HLT. It drives the same
//   bus/ALU/register strobes as the current control unit.
// - Sits between the instruction register (ri), the flag register (ind), the
//   RAM and the datapath; it alone sequences all bus transfers.
// PARAMETERS
// - WORD_WIDTH      16  width of ri and ind
// - STATE_WIDTH     16  width of disp_state (state code, zero-extended)
// - ZF_BIT          1   bit index of the zero flag in ind
// - TIMEOUT_CYCLES  16  maximum wait cycles per memory access (only with UC_TIMEOUT_EN)
// PORTS
// - clk          in   1              rising-edge clock
// - rst          in   1              asynchronous reset, active-low
// - ri           in   WORD_WIDTH     instruction: opcode=ri[WW-1:WW-4], reg=ri[2:0]
// - ind          in   WORD_WIDTH     flags; ind[ZF_BIT] = zero flag
// - ram_rdy      in   1              RAM data valid on the bus this cycle
// - regs_addr    out  3              register file address
// - regs_oe/we, alu_oe, alu_carry, ram_oe, ram_we, io_oe, io_we, cp_oe/we,
//   ind_sel/oe/we, am_oe/we, aie_oe/we, t1_oe/we, t2_oe/we, ri_oe/we
//                out  1 each         datapath strobes
// - alu_opcode   out  4              ALU operation (0 = ADC)
// - halted       out  1              high while in HALT
// - illegal_op   out  1              1-cycle pulse on an unknown opcode
// - bus_fault    out  1              1-cycle pulse on a memory timeout
// - disp_state   out  STATE_WIDTH    current state code
// BEHAVIOUR
// - State register with async reset to RESET(0). Outputs decode
//   combinationally from state (plus ram_rdy where noted).
// - Reset value of every output, and its value in RESET: 0. RESET -> F0
//   unconditionally. rst asserted in any state, including mid-wait, returns
//   to RESET immediately; no strobe stays high.
// - F0(1): cp_oe, am_we -> F1. F1(2): am_oe -> F2.
// - F2(3): am_oe, ram_oe; ri_we = ram_rdy. Stay in F2 while !ram_rdy; else -> C0.
// - C0(4): cp_oe, t1_we -> C1.
// - C1(5): t1_oe, alu_oe, alu_opcode=0, alu_carry=1, cp_we (CP+1). Next state
//   by opcode:
//   - 0 NOP -> F0; 1 INC -> I0; 2 LD -> L0; 3 JMP -> J0
//   - 4 JZ -> J0 if ind[ZF_BIT], else S0
//   - F HLT -> HALT
//   - other: illegal_op=1 -> F0
// - I0(10): regs_addr=ri[2:0], regs_oe, t1_we -> I1.
// - I1(11): t1_oe, alu_oe, ADC, carry=1, regs_we, regs_addr=ri[2:0], ind_sel=1,
//   ind_we -> F0.
// - L0(20): cp_oe, am_we -> L1. L1(21): am_oe -> L2.
// - L2(22): am_oe, ram_oe, regs_addr=ri[2:0]; regs_we = ram_rdy. Wait while
//   !ram_rdy; else -> S0.
// - S0(24) = C0 strobes -> S1. S1(25) = C1 strobes -> F0 (skips the operand word).
// - J0(30): cp_oe, am_we -> J1. J1(31): am_oe -> J2.
// - J2(32): am_oe, ram_oe; cp_we = ram_rdy. Wait while !ram_rdy; else -> F0.
// - HALT(63): halted=1, all strobes 0; left only via rst.
// - Latency with zero-wait RAM: NOP 5, INC 7, JMP 8, LD 10 cycles. Each
//   ram_rdy-low cycle adds 1.
// - ram_rdy outside F2/L2/J2 is ignored. Never two *_oe on the bus in the same cycle.
// CONFIGURATION
// - UC_TIMEOUT_EN defined:
//   - an 8-bit wait counter clears on entry to F2, L2 or J2 and counts each
//     !ram_rdy cycle there.
//   - if it reaches TIMEOUT_CYCLES-1 while ram_rdy=0: bus_fault pulses 1 cycle
//     and the FSM goes to HALT; no write strobe fires.
//   - ram_rdy in that same cycle wins: normal completion.
// - UC_TIMEOUT_EN undefined: waits indefinitely; bus_fault tied 0; no counter.
// TESTING
// - Reset: rst=0 mid-F2 wait -> state 0 and all strobes 0 same cycle; release
//   -> F0 next edge.
// - INC r3, ram_rdy always 1 -> I1 shows regs_addr=3, regs_we, ind_we, ind_sel;
//   7 cycles F0-to-F0.
// - LD r5 with ram_rdy low for 3 cycles in L2 -> regs_we only in the rdy
//   cycle; CP advanced by 2 total.
// - JZ with ind[1]=1 -> cp_we in J2. With ind[1]=0 -> path S0/S1; J states
//   never entered.
// - Opcode 0xA -> illegal_op pulses once, back in F0. Opcode 0xF -> halted=1
//   held for 100 cycles.
// - UC_TIMEOUT_EN, TIMEOUT_CYCLES=16, ram_rdy stuck 0 in F2 -> bus_fault after
//   16 wait cycles, then HALT. Macro off -> still in F2 after 1000 cycles.

Source files
------------

// File: rtl/uc_seq.sv
// Microcoded control sequencer for the didactic calculator: fetch with a ram_rdy
// wait-state handshake, then NOP/INC/LD/JMP/JZ/HLT execution. Optional UC_TIMEOUT_EN adds a memory-wait watchdog.
`timescale 1ns/1ps
module uc_seq #(
  parameter int WORD_WIDTH     = 16,
  parameter int STATE_WIDTH    = 16,
  parameter int ZF_BIT         = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_WIDTH-1:0]  ri,
  input  logic [WORD_WIDTH-1:0]  ind,
  input  logic                   ram_rdy,
  output logic [2:0]             regs_addr,
  output logic                   regs_oe,
  output logic                   regs_we,
  output logic                   alu_oe,
  output logic                   alu_carry,
  output logic [3:0]             alu_opcode,
  output logic                   ram_oe,
  output logic                   ram_we,
  output logic                   io_oe,
  output logic                   io_we,
  output logic                   cp_oe,
  output logic                   cp_we,
  output logic                   ind_sel,
  output logic                   ind_oe,
  output logic                   ind_we,
  output logic                   am_oe,
  output logic                   am_we,
  output logic                   aie_oe,
  output logic                   aie_we,
  output logic                   t1_oe,
  output logic                   t1_we,
  output logic                   t2_oe,
  output logic                   t2_we,
  output logic                   ri_oe,
  output logic                   ri_we,
  output logic                   halted,
  output logic                   illegal_op,
  output logic                   bus_fault,
  output logic [STATE_WIDTH-1:0] disp_state
);

  typedef enum logic [5:0] {
    ST_RESET = 6'd0,
    ST_F0    = 6'd1,
    ST_F1    = 6'd2,
    ST_F2    = 6'd3,
    ST_C0    = 6'd4,
    ST_C1    = 6'd5,
    ST_I0    = 6'd10,
    ST_I1    = 6'd11,
    ST_L0    = 6'd20,
    ST_L1    = 6'd21,
    ST_L2    = 6'd22,
    ST_S0    = 6'd24,
    ST_S1    = 6'd25,
    ST_J0    = 6'd30,
    ST_J1    = 6'd31,
    ST_J2    = 6'd32,
    ST_HALT  = 6'd63
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_INC = 4'h1,
    OP_LD  = 4'h2,
    OP_JMP = 4'h3,
    OP_JZ  = 4'h4,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [3:0] ALU_ADC = 4'd0;

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic [2:0] reg_sel;
  logic       zero_flag;
  logic       known_op;
  logic       timeout;
  logic       unused_bits;

  assign opcode      = ri[WORD_WIDTH-1 -: 4];
  assign reg_sel     = ri[2:0];
  assign zero_flag   = ind[ZF_BIT];
  assign unused_bits = ^{ri[WORD_WIDTH-5:3], ind};
  assign disp_state  = STATE_WIDTH'(state_q);

  always_comb begin
    case (opcode)
      OP_NOP, OP_INC, OP_LD, OP_JMP, OP_JZ, OP_HLT: known_op = 1'b1;
      default:                                      known_op = 1'b0;
    endcase
  end

`ifdef UC_TIMEOUT_EN
  // Counts consecutive !ram_rdy cycles in a wait state; it returns to zero
  // whenever the FSM is not waiting, so every wait-state entry starts at zero.
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       in_wait;

  assign in_wait = (state_q == ST_F2) || (state_q == ST_L2) || (state_q == ST_J2);
  assign timeout = in_wait && !ram_rdy && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = (in_wait && !ram_rdy) ? wait_cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= 8'd0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_F0;
      ST_F0:    state_d = ST_F1;
      ST_F1:    state_d = ST_F2;
      ST_F2:    if (timeout) state_d = ST_HALT;
                else if (ram_rdy) state_d = ST_C0;
      ST_C0:    state_d = ST_C1;
      ST_C1: begin
        case (opcode)
          OP_NOP:  state_d = ST_F0;
          OP_INC:  state_d = ST_I0;
          OP_LD:   state_d = ST_L0;
          OP_JMP:  state_d = ST_J0;
          OP_JZ:   state_d = zero_flag ? ST_J0 : ST_S0;
          OP_HLT:  state_d = ST_HALT;
          default: state_d = ST_F0;
        endcase
      end
      ST_I0:    state_d = ST_I1;
      ST_I1:    state_d = ST_F0;
      ST_L0:    state_d = ST_L1;
      ST_L1:    state_d = ST_L2;
      ST_L2:    if (timeout) state_d = ST_HALT;
                else if (ram_rdy) state_d = ST_S0;
      ST_S0:    state_d = ST_S1;
      ST_S1:    state_d = ST_F0;
      ST_J0:    state_d = ST_J1;
      ST_J1:    state_d = ST_J2;
      ST_J2:    if (timeout) state_d = ST_HALT;
                else if (ram_rdy) state_d = ST_F0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // NOTE: every output gets a default before the case so no path through the
  // block leaves an output unassigned, which would infer a latch.
  always_comb begin
    regs_addr  = 3'd0;
    regs_oe    = 1'b0;
    regs_we    = 1'b0;
    alu_oe     = 1'b0;
    alu_carry  = 1'b0;
    alu_opcode = ALU_ADC;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    io_oe      = 1'b0;
    io_we      = 1'b0;
    cp_oe      = 1'b0;
    cp_we      = 1'b0;
    ind_sel    = 1'b0;
    ind_oe     = 1'b0;
    ind_we     = 1'b0;
    am_oe      = 1'b0;
    am_we      = 1'b0;
    aie_oe     = 1'b0;
    aie_we     = 1'b0;
    t1_oe      = 1'b0;
    t1_we      = 1'b0;
    t2_oe      = 1'b0;
    t2_we      = 1'b0;
    ri_oe      = 1'b0;
    ri_we      = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    bus_fault  = timeout;
    case (state_q)
      ST_F0, ST_L0, ST_J0: begin
        cp_oe = 1'b1;
        am_we = 1'b1;
      end
      ST_F1, ST_L1, ST_J1: am_oe = 1'b1;
      ST_F2: begin
        am_oe  = 1'b1;
        ram_oe = 1'b1;
        ri_we  = ram_rdy;
      end
      ST_C0, ST_S0: begin
        cp_oe = 1'b1;
        t1_we = 1'b1;
      end
      ST_C1, ST_S1: begin
        t1_oe      = 1'b1;
        alu_oe     = 1'b1;
        alu_carry  = 1'b1;
        cp_we      = 1'b1;
        illegal_op = (state_q == ST_C1) && !known_op;
      end
      ST_I0: begin
        regs_addr = reg_sel;
        regs_oe   = 1'b1;
        t1_we     = 1'b1;
      end
      ST_I1: begin
        t1_oe     = 1'b1;
        alu_oe    = 1'b1;
        alu_carry = 1'b1;
        regs_we   = 1'b1;
        regs_addr = reg_sel;
        ind_sel   = 1'b1;
        ind_we    = 1'b1;
      end
      ST_L2: begin
        am_oe     = 1'b1;
        ram_oe    = 1'b1;
        regs_addr = reg_sel;
        regs_we   = ram_rdy;
      end
      ST_J2: begin
        am_oe  = 1'b1;
        ram_oe = 1'b1;
        cp_we  = ram_rdy;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: instruction vectors with a per-cycle state/strobe
// scoreboard, plus reset, halt and memory-timeout sequences.
`timescale 1ns/1ps
module tb_uc_seq;

  localparam int WW = 16;
  localparam int SW = 16;

  localparam int S_RESET = 0,  S_F0 = 1,  S_F1 = 2,  S_F2 = 3,  S_C0 = 4,  S_C1 = 5;
  localparam int S_I0 = 10, S_I1 = 11, S_L0 = 20, S_L1 = 21, S_L2 = 22, S_S0 = 24;
  localparam int S_S1 = 25, S_J0 = 30, S_J1 = 31, S_J2 = 32, S_HALT = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WW-1:0] ri = '0;
  logic [WW-1:0] ind = '0;
  logic          ram_rdy = 1'b0;
  logic [2:0]    regs_addr;
  logic          regs_oe, regs_we, alu_oe, alu_carry;
  logic [3:0]    alu_opcode;
  logic          ram_oe, ram_we, io_oe, io_we, cp_oe, cp_we;
  logic          ind_sel, ind_oe, ind_we, am_oe, am_we, aie_oe, aie_we;
  logic          t1_oe, t1_we, t2_oe, t2_we, ri_oe, ri_we;
  logic          halted, illegal_op, bus_fault;
  logic [SW-1:0] disp_state;

  uc_seq dut (
    .clk(clk), .rst(rst), .ri(ri), .ind(ind), .ram_rdy(ram_rdy),
    .regs_addr(regs_addr), .regs_oe(regs_oe), .regs_we(regs_we),
    .alu_oe(alu_oe), .alu_carry(alu_carry), .alu_opcode(alu_opcode),
    .ram_oe(ram_oe), .ram_we(ram_we), .io_oe(io_oe), .io_we(io_we),
    .cp_oe(cp_oe), .cp_we(cp_we), .ind_sel(ind_sel), .ind_oe(ind_oe), .ind_we(ind_we),
    .am_oe(am_oe), .am_we(am_we), .aie_oe(aie_oe), .aie_we(aie_we),
    .t1_oe(t1_oe), .t1_we(t1_we), .t2_oe(t2_oe), .t2_we(t2_we),
    .ri_oe(ri_oe), .ri_we(ri_we), .halted(halted), .illegal_op(illegal_op),
    .bus_fault(bus_fault), .disp_state(disp_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] regs_addr;
    logic       regs_oe, regs_we, alu_oe, alu_carry;
    logic [3:0] alu_opcode;
    logic       ram_oe, ram_we, io_oe, io_we, cp_oe, cp_we;
    logic       ind_sel, ind_oe, ind_we, am_oe, am_we, aie_oe, aie_we;
    logic       t1_oe, t1_we, t2_oe, t2_we, ri_oe, ri_we;
    logic       halted, illegal_op, bus_fault;
  } strobes_t;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rg;
    logic       zf;
    int         fwait;
    int         dwait;
    int         lat;
    int         cpw;
    int         end_st;
  } vec_t;

  typedef struct {
    int   st;
    logic rdy;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic strobes_t observe();
    strobes_t s;
    s.regs_addr = regs_addr;   s.regs_oe = regs_oe;   s.regs_we = regs_we;
    s.alu_oe = alu_oe;         s.alu_carry = alu_carry; s.alu_opcode = alu_opcode;
    s.ram_oe = ram_oe;         s.ram_we = ram_we;     s.io_oe = io_oe;   s.io_we = io_we;
    s.cp_oe = cp_oe;           s.cp_we = cp_we;       s.ind_sel = ind_sel;
    s.ind_oe = ind_oe;         s.ind_we = ind_we;     s.am_oe = am_oe;   s.am_we = am_we;
    s.aie_oe = aie_oe;         s.aie_we = aie_we;     s.t1_oe = t1_oe;   s.t1_we = t1_we;
    s.t2_oe = t2_oe;           s.t2_we = t2_we;       s.ri_oe = ri_oe;   s.ri_we = ri_we;
    s.halted = halted;         s.illegal_op = illegal_op; s.bus_fault = bus_fault;
    return s;
  endfunction

  // Expected strobes for one cycle, written from the state table.
  function automatic strobes_t expect_strobes(input int st, input logic [2:0] rg,
                                              input logic [3:0] op, input logic rdy);
    strobes_t s;
    s = '0;
    case (st)
      S_F0, S_L0, S_J0: begin s.cp_oe = 1'b1; s.am_we = 1'b1; end
      S_F1, S_L1, S_J1: s.am_oe = 1'b1;
      S_F2: begin s.am_oe = 1'b1; s.ram_oe = 1'b1; s.ri_we = rdy; end
      S_C0, S_S0: begin s.cp_oe = 1'b1; s.t1_we = 1'b1; end
      S_C1, S_S1: begin
        s.t1_oe = 1'b1; s.alu_oe = 1'b1; s.alu_carry = 1'b1; s.cp_we = 1'b1;
        if (st == S_C1 && !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF})) s.illegal_op = 1'b1;
      end
      S_I0: begin s.regs_addr = rg; s.regs_oe = 1'b1; s.t1_we = 1'b1; end
      S_I1: begin
        s.t1_oe = 1'b1; s.alu_oe = 1'b1; s.alu_carry = 1'b1; s.regs_we = 1'b1;
        s.regs_addr = rg; s.ind_sel = 1'b1; s.ind_we = 1'b1;
      end
      S_L2: begin s.am_oe = 1'b1; s.ram_oe = 1'b1; s.regs_addr = rg; s.regs_we = rdy; end
      S_J2: begin s.am_oe = 1'b1; s.ram_oe = 1'b1; s.cp_we = rdy; end
      S_HALT: s.halted = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  function automatic exp_t mk(input int st, input logic rdy);
    exp_t e;
    e.st = st;
    e.rdy = rdy;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected state path of one instruction, with the ram_rdy value to drive in each cycle.
  task automatic push_seq(input vec_t v);
    sb_q.push_back(mk(S_F0, rnd()));
    sb_q.push_back(mk(S_F1, rnd()));
    for (int i = 0; i < v.fwait; i++) sb_q.push_back(mk(S_F2, 1'b0));
    sb_q.push_back(mk(S_F2, 1'b1));
    sb_q.push_back(mk(S_C0, rnd()));
    sb_q.push_back(mk(S_C1, rnd()));
    if (v.op == 4'h1) begin
      sb_q.push_back(mk(S_I0, rnd()));
      sb_q.push_back(mk(S_I1, rnd()));
    end else if (v.op == 4'h2) begin
      sb_q.push_back(mk(S_L0, rnd()));
      sb_q.push_back(mk(S_L1, rnd()));
      for (int i = 0; i < v.dwait; i++) sb_q.push_back(mk(S_L2, 1'b0));
      sb_q.push_back(mk(S_L2, 1'b1));
      sb_q.push_back(mk(S_S0, rnd()));
      sb_q.push_back(mk(S_S1, rnd()));
    end else if (v.op == 4'h3 || (v.op == 4'h4 && v.zf)) begin
      sb_q.push_back(mk(S_J0, rnd()));
      sb_q.push_back(mk(S_J1, rnd()));
      for (int i = 0; i < v.dwait; i++) sb_q.push_back(mk(S_J2, 1'b0));
      sb_q.push_back(mk(S_J2, 1'b1));
    end else if (v.op == 4'h4) begin
      sb_q.push_back(mk(S_S0, rnd()));
      sb_q.push_back(mk(S_S1, rnd()));
    end
  endtask

  // Entered at a negedge with the DUT in F0; returns at the negedge where it is
  // back in F0 (or HALT).
  task automatic run_vec(input vec_t v, input int idx);
    int       cyc = 0;
    int       cpw = 0;
    exp_t     e;
    strobes_t req;
    ri = {v.op, 9'($urandom), v.rg};
    ind = WW'($urandom);
    ind[1] = v.zf;
    push_seq(v);
    while (cyc < 200) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        req = expect_strobes(e.st, v.rg, v.op, e.rdy);
        check($sformatf("v%0d cyc%0d state", idx, cyc), 64'(disp_state), 64'(e.st));
        check($sformatf("v%0d cyc%0d strobes", idx, cyc), 64'(observe()), 64'(req));
      end
      if (cp_we) cpw++;
      cyc++;
      @(posedge clk);
      #1;
      ram_rdy = (sb_q.size() > 0) ? sb_q[0].rdy : 1'b1;
      @(negedge clk);
      if (disp_state == SW'(S_F0) || disp_state == SW'(S_HALT)) break;
    end
    check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
    check($sformatf("v%0d cp_we pulses", idx), 64'(cpw), 64'(v.cpw));
    check($sformatf("v%0d end state", idx), 64'(disp_state), 64'(v.end_st));
    if (sb_q.size() != 0) begin
      check($sformatf("v%0d unconsumed expectations", idx), 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ram_rdy = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int   bad;
    int   w;
    int   cyc;
    logic done;
    vec_t nop_v;

    //             op     rg    zf    fw dw lat cpw end
    vecs[0]  = '{4'h0, 3'd0, 1'b0, 0, 0, 5,  1, S_F0};   // NOP
    vecs[1]  = '{4'h1, 3'd3, 1'b0, 0, 0, 7,  1, S_F0};   // INC r3
    vecs[2]  = '{4'h2, 3'd5, 1'b0, 0, 3, 13, 2, S_F0};   // LD r5, 3 wait cycles
    vecs[3]  = '{4'h3, 3'd1, 1'b0, 0, 0, 8,  2, S_F0};   // JMP
    vecs[4]  = '{4'h4, 3'd2, 1'b1, 0, 0, 8,  2, S_F0};   // JZ taken
    vecs[5]  = '{4'h4, 3'd2, 1'b0, 0, 0, 7,  2, S_F0};   // JZ not taken
    vecs[6]  = '{4'hA, 3'd0, 1'b0, 0, 0, 5,  1, S_F0};   // illegal
    vecs[7]  = '{4'h0, 3'd0, 1'b1, 2, 0, 7,  1, S_F0};   // NOP, fetch waits
    vecs[8]  = '{4'h1, 3'd7, 1'b1, 1, 0, 8,  1, S_F0};   // INC r7, fetch wait
    vecs[9]  = '{4'h3, 3'd6, 1'b1, 0, 2, 10, 2, S_F0};   // JMP, J2 waits
    vecs[10] = '{4'h2, 3'd0, 1'b0, 1, 1, 12, 2, S_F0};   // LD r0, both waits
    vecs[11] = '{4'h7, 3'd4, 1'b1, 0, 0, 5,  1, S_F0};   // illegal
    vecs[12] = '{4'h4, 3'd1, 1'b1, 1, 1, 10, 2, S_F0};   // JZ taken, waits
    vecs[13] = '{4'hF, 3'd0, 1'b0, 0, 0, 5,  1, S_HALT}; // HLT
    nop_v    = vecs[0];

    // Reset state
    #12;
    check("reset state", 64'(disp_state), 64'(S_RESET));
    check("reset strobes", 64'(observe()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("release to F0", 64'(disp_state), 64'(S_F0));

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // HALT is held regardless of ram_rdy
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1 ram_rdy = rnd();
      @(negedge clk);
      if (disp_state != SW'(S_HALT) || observe() != expect_strobes(S_HALT, 3'd0, 4'hF, ram_rdy)) bad++;
    end
    check("halt held 100 cycles", 64'(bad), 64'd0);
    check("halted flag", 64'(halted), 64'd1);
    do_reset();

    // Async reset in the middle of an F2 wait
    ri = '0;
    repeat (3) begin
      @(posedge clk);
      #1 ram_rdy = 1'b0;
    end
    check("pre-reset in F2", 64'(disp_state), 64'(S_F2));
    #1 rst = 1'b0;
    #1;
    check("mid-wait reset state", 64'(disp_state), 64'(S_RESET));
    check("mid-wait reset strobes", 64'(observe()), 64'd0);
    ram_rdy = 1'b1;
    #1;
    check("reset ignores ram_rdy", 64'(observe()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ram_rdy = 1'b0;
    @(negedge clk);
    check("post-reset F0", 64'(disp_state), 64'(S_F0));
    run_vec(nop_v, 100);

    ri = '0;
`ifdef UC_TIMEOUT_EN
    // Fetch wait that never completes
    w = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 ram_rdy = 1'b0;
      @(negedge clk);
      cyc++;
      if (disp_state == SW'(S_F2)) w++;
      if (bus_fault) done = 1'b1;
    end
    check("timeout detected", 64'(done), 64'd1);
    check("timeout wait cycles", 64'(w), 64'd16);
    check("no ri_we on timeout", 64'(ri_we), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("timeout to HALT", 64'(disp_state), 64'(S_HALT));
    check("bus_fault single pulse", 64'(bus_fault), 64'd0);
    do_reset();

    // ram_rdy arriving in the last allowed wait cycle wins
    w = 0; cyc = 0;
    while (w < 16 && cyc < 100) begin
      @(posedge clk);
      #1;
      if (disp_state == SW'(S_F2)) begin
        w++;
        ram_rdy = (w == 16);
      end else ram_rdy = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("late rdy no bus_fault", 64'(bus_fault), 64'd0);
    check("late rdy ri_we", 64'(ri_we), 64'd1);
    @(posedge clk);
    #1 ram_rdy = 1'b0;
    @(negedge clk);
    check("late rdy to C0", 64'(disp_state), 64'(S_C0));
`else
    // Without the watchdog the fetch waits indefinitely
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 ram_rdy = 1'b0;
      @(negedge clk);
      if (i >= 1 && (disp_state != SW'(S_F2) || bus_fault || ri_we)) bad++;
    end
    check("endless F2 wait", 64'(bad), 64'd0);
    check("still in F2", 64'(disp_state), 64'(S_F2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
